// File: rtl/vector_capture_pkg.sv
// Purpose : shared types and helpers for the vector output capture block.
// Latency : n/a (types, constants and constant functions only).
// Backpressure: n/a.
package vector_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Bit offset of lane idx inside a packed vector word.
    function automatic int lane_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vector_capture_fifo.sv
// Purpose : synchronous FIFO holding captured vector words.
// Latency : push visible at o_dout / o_level one cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports   : i_clk, i_rst_n (async active-low), i_push/i_din, i_pop,
//           o_dout (head word), o_full, o_empty, o_level (words held).
module vector_capture_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vector_output_capture.sv
// Purpose : frame-bounded capture of CPU vector outputs, serialised lane by lane onto a byte stream.
// Latency : captured word's first beat valid one cycle after out_flag; words stream back-to-back.
// Backpressure: m_ready stalls the stream; CPU side has none, so a full FIFO drops words (sticky overflow).
// Ports   : clock, reset (async active-low); out_data/out_flag from the CPU; start/frame_len frame
//           control; m_data/m_valid/m_ready/m_last stream; busy, frame_done, overflow, fifo_level,
//           checksum status. Define VOC_CHECKSUM_EN to enable the running beat checksum.
module vector_output_capture
    import vector_capture_pkg::*;
#(
    parameter int LANES        = 6,
    parameter int OUTPUT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int LEN_WIDTH    = 20
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [LANES*OUTPUT_WIDTH-1:0] out_data,
    input  logic                          out_flag,
    input  logic                          start,
    input  logic [LEN_WIDTH-1:0]          frame_len,
    output logic [OUTPUT_WIDTH-1:0]       m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [OUTPUT_WIDTH-1:0]       checksum
);
    localparam int VEC_W      = LANES * OUTPUT_WIDTH;
    localparam int LANE_IDX_W = lane_idx_w(LANES);
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    cap_state_t              r_state;
    cap_state_t              w_state_nxt;
    logic [LEN_WIDTH-1:0]    r_frame_len;
    logic [LEN_WIDTH-1:0]    r_captured;
    logic [LANE_IDX_W-1:0]   r_lane;
    logic                    r_overflow;
    logic                    r_frame_done;

    logic                    w_start_ok;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_hs;
    logic                    w_lane_last;
    logic                    w_capture_end;
    logic [VEC_W-1:0]        w_head;
    logic [OUTPUT_WIDTH-1:0] w_lane_dat;
    logic [LVL_W-1:0]        w_level;

    assign w_start_ok    = (r_state == IDLE) && start;
    assign w_push        = (r_state == CAPTURE) && out_flag;
    assign w_capture_end = w_push && ((r_captured + LEN_WIDTH'(1)) == r_frame_len);

    // The serializer works straight off the FIFO head and pops only after the
    // final lane, so a word being emitted still counts in fifo_level.
    assign m_valid     = !w_empty;
    assign w_hs        = m_valid && m_ready;
    assign w_lane_last = (r_lane == LANE_IDX_W'(LANES - 1));
    assign w_pop       = w_hs && w_lane_last;

    vector_capture_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_din   (out_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_lane_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane == LANE_IDX_W'(i)) begin
                w_lane_dat = w_head[lane_lsb(i, OUTPUT_WIDTH) +: OUTPUT_WIDTH];
            end
        end
    end

    assign m_data = m_valid ? w_lane_dat : '0;
    // Nothing is pushed in DRAIN, so a single held word there is the frame's
    // last stored vector -- this also covers frames whose tail was dropped.
    assign m_last     = m_valid && w_lane_last && (r_state == DRAIN) && (w_level == LVL_W'(1));
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (frame_len == '0) ? DONE : CAPTURE;
            CAPTURE: if (w_capture_end) w_state_nxt = DRAIN;
            DRAIN:   if (w_empty) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_frame_len  <= '0;
            r_captured   <= '0;
            r_lane       <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= (r_state == DONE);
            if (w_start_ok) begin
                r_frame_len <= frame_len;
                r_captured  <= '0;
                r_overflow  <= 1'b0;
            end else if (w_push) begin
                // Frame length counts CPU outputs, including dropped ones.
                r_captured <= r_captured + LEN_WIDTH'(1);
                if (w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_hs) begin
                r_lane <= w_lane_last ? '0 : r_lane + LANE_IDX_W'(1);
            end
        end
    end

`ifdef VOC_CHECKSUM_EN
    logic [OUTPUT_WIDTH-1:0] r_checksum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_hs) begin
            r_checksum <= r_checksum + m_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_vector_output_capture.sv
// Purpose : self-checking bench for vector_output_capture (built with FIFO_DEPTH=4).
// Latency : n/a.
// Backpressure: m_ready driven constant high/low or toggling every cycle.
module tb_vector_output_capture;

    localparam int LN = 6;
    localparam int OW = 8;

    logic           clock;
    logic           reset;
    logic [LN*OW-1:0] out_data;
    logic           out_flag;
    logic           start;
    logic [19:0]    frame_len;
    logic [OW-1:0]  m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic           busy;
    logic           frame_done;
    logic           overflow;
    logic [2:0]     fifo_level;
    logic [OW-1:0]  checksum;

    logic rdy_base;
    logic tog_en;
    logic tog;

    assign m_ready = tog_en ? tog : rdy_base;

    vector_output_capture #(
        .LANES        (LN),
        .OUTPUT_WIDTH (OW),
        .FIFO_DEPTH   (4),
        .LEN_WIDTH    (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .out_data   (out_data),
        .out_flag   (out_flag),
        .start      (start),
        .frame_len  (frame_len),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .checksum   (checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        tog = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tog = ~tog;
        end
    end

    typedef struct {
        logic [OW-1:0] dat;
        logic          last;
    } beat_t;

    beat_t          exp_q[$];
    logic [OW-1:0]  seen[$];
    logic [OW-1:0]  cks_model;
    int             done_cnt;
    int             n_checks;
    int             n_fail;

    localparam logic [47:0] W0 = 48'h060504030201;
    localparam logic [47:0] W1 = 48'h0C0B0A090807;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats for one stored word, lane 0 first.
    task automatic expect_word(input logic [47:0] w, input bit is_last);
        for (int l = 0; l < LN; l++) begin
            beat_t b;
            b.dat  = w[l*OW +: OW];
            b.last = is_last && (l == LN - 1);
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [47:0] mk_word(input int k);
        logic [47:0] w;
        w = '0;
        for (int l = 0; l < LN; l++) begin
            w[l*OW +: OW] = {4'(k + 1), 4'(l)};
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [19:0] len);
        start     = 1'b1;
        frame_len = len;
        step();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [47:0] w);
        out_data = w;
        out_flag = 1'b1;
        step();
        out_flag = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == c0; i++) begin
            @(negedge clock);
        end
        chk({tag, "_frame_done_count"}, 64'(done_cnt - c0), 64'd1);
        step();
    endtask

    // Two-word frame with the reference data; beats 01..0C, sum 0x4E.
    task automatic run_basic(input string tag);
        seen.delete();
        expect_word(W0, 1'b0);
        expect_word(W1, 1'b1);
        do_start(20'd2);
        send_word(W0);
        send_word(W1);
        wait_done(tag, 400);
        chk({tag, "_beats"}, 64'(seen.size()), 64'd12);
        chk({tag, "_first_beat"}, 64'(seen[0]), 64'h01);
        chk({tag, "_last_beat"}, 64'(seen[11]), 64'h0C);
        chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
`ifdef VOC_CHECKSUM_EN
        chk({tag, "_checksum"}, 64'(checksum), 64'h4E);
`else
        chk({tag, "_checksum"}, 64'(checksum), 64'h00);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(m_last), 64'd0);
        chk({tag, "_m_data"}, 64'(m_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    // Compare process: every cycle, stream beats against the expected queue,
    // stall stability, checksum against a running sum, single-cycle frame_done.
    initial begin
        logic [OW-1:0] prev_dat;
        logic          prev_stall;
        logic          prev_fd;
        beat_t         e;
        prev_dat   = '0;
        prev_stall = 1'b0;
        prev_fd    = 1'b0;
        cks_model  = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_stall = 1'b0;
                prev_fd    = 1'b0;
                cks_model  = '0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_held", 64'(m_valid), 64'd1);
                    chk("stall_data_held", 64'(m_data), 64'(prev_dat));
                end
                if (m_valid) begin
                    chk("beat_pending", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        if (m_ready) begin
                            e = exp_q.pop_front();
                            seen.push_back(m_data);
                        end else begin
                            e = exp_q[0];
                        end
                        chk("beat_data", 64'(m_data), 64'(e.dat));
                        chk("beat_last", 64'(m_last), 64'(e.last));
                    end
                end
`ifdef VOC_CHECKSUM_EN
                chk("checksum_run", 64'(checksum), 64'(cks_model));
`else
                chk("checksum_off", 64'(checksum), 64'd0);
`endif
                if (start && !busy) begin
                    cks_model = '0;
                end else if (m_valid && m_ready) begin
                    cks_model = cks_model + m_data;
                end
                if (frame_done) begin
                    done_cnt++;
                    chk("frame_done_single", 64'(prev_fd), 64'd0);
                end
                prev_stall = m_valid && !m_ready;
                prev_dat   = m_data;
                prev_fd    = frame_done;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        n_checks  = 0;
        n_fail    = 0;
        done_cnt  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        frame_len = '0;
        out_data  = '0;
        out_flag  = 1'b0;
        rdy_base  = 1'b0;
        tog_en    = 1'b0;

        repeat (2) step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();

        // 1: basic two-word frame, sink always ready.
        rdy_base = 1'b1;
        run_basic("t1");

        // 2: same frame with m_ready toggling every cycle.
        seen.delete();
        tog_en = 1'b1;
        expect_word(W0, 1'b0);
        expect_word(W1, 1'b1);
        do_start(20'd2);
        send_word(W0);
        send_word(W1);
        wait_done("t2", 600);
        tog_en = 1'b0;
        chk("t2_beats", 64'(seen.size()), 64'd12);
        chk("t2_beat5", 64'(seen[5]), 64'h06);
        chk("t2_beat11", 64'(seen[11]), 64'h0C);

        // 3: sink stalled, six outputs into a four-deep FIFO -> two dropped.
        seen.delete();
        rdy_base = 1'b0;
        for (int k = 0; k < 4; k++) expect_word(mk_word(k), k == 3);
        do_start(20'd6);
        for (int k = 0; k < 6; k++) send_word(mk_word(k));
        step();
        @(negedge clock);
        chk("t3_level_full", 64'(fifo_level), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        step();
        rdy_base = 1'b1;
        wait_done("t3", 600);
        chk("t3_beats", 64'(seen.size()), 64'd24);
        chk("t3_first_beat", 64'(seen[0]), 64'h10);
        chk("t3_last_beat", 64'(seen[23]), 64'h45);
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);
        chk("t3_exp_left", 64'(exp_q.size()), 64'd0);

        // 4: out_flag in IDLE is ignored; zero-length frame completes at once.
        for (int k = 0; k < 3; k++) send_word(48'hA5A5A5A5A5A5);
        @(negedge clock);
        chk("t4_idle_level", 64'(fifo_level), 64'd0);
        step();
        fd0 = done_cnt;
        start     = 1'b1;
        frame_len = 20'd0;
        step();
        start     = 1'b0;
        @(negedge clock);
        chk("t4_busy_c1", 64'(busy), 64'd1);
        chk("t4_fd_c1", 64'(frame_done), 64'd0);
        chk("t4_overflow_cleared", 64'(overflow), 64'd0);
        @(negedge clock);
        chk("t4_fd_c2", 64'(frame_done), 64'd1);
        chk("t4_busy_c2", 64'(busy), 64'd0);
        @(negedge clock);
        chk("t4_fd_c3", 64'(frame_done), 64'd0);
        chk("t4_fd_count", 64'(done_cnt - fd0), 64'd1);
        step();

        // 5: reset asserted while draining a stalled frame.
        rdy_base = 1'b0;
        expect_word(W0, 1'b0);
        expect_word(W1, 1'b1);
        do_start(20'd2);
        send_word(W0);
        send_word(W1);
        @(negedge clock);
        chk("t5_busy_drain", 64'(busy), 64'd1);
        chk("t5_level_drain", 64'(fifo_level), 64'd2);
        step();
        fd0 = done_cnt;
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk_all_zero("t5_async");
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("t5_no_frame_done", 64'(done_cnt - fd0), 64'd0);
        rdy_base = 1'b1;
        run_basic("t5_next");

        // 6: checksum held after frame_done.
        repeat (4) step();
`ifdef VOC_CHECKSUM_EN
        chk("t6_checksum_held", 64'(checksum), 64'h4E);
`else
        chk("t6_checksum_off", 64'(checksum), 64'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
